// File: rtl/bus_cycle_ctrl.sv
// 8088 bus-cycle sequencer: latches the address on ALE, decodes one of NREG regions,
// drives chip-select and shared OE_n/WE_n strobes and stretches cycles with per-region waits.
module bus_cycle_ctrl #(
  parameter int NREG         = 5,
  parameter int WAIT_W       = 3,
  parameter int DEFAULT_WAIT = 1,
  parameter int TIMEOUT      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic [19:0]       A,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [WAIT_W-1:0] cfg_wait,
  output logic [19:0]       LADDR,
  output logic [NREG-1:0]   CS_n,
  output logic              OE_n,
  output logic              WE_n,
  output logic              READY,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_ADDR = 5'b00010,
    S_WAIT = 5'b00100,
    S_ACC  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          region_q, region_d;
  logic [19:0]         laddr_q, laddr_d;
  logic                dir_q, dir_d;        // 1 = write
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [WAIT_W-1:0]   wait_q [NREG];
  logic [WAIT_W-1:0]   wait_d [NREG];
  logic [NREG-1:0]     cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  // Next-state and datapath for the bus-cycle sequencer.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    laddr_d  = laddr_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ALE) begin
          laddr_d  = A;
          region_d = IOM ? 3'd4 : {1'b0, A[19:18]};
          tcnt_d   = '0;
          state_d  = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (!RD_n && !WR_n) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!RD_n || !WR_n) begin
          // Count is captured here, so later config writes leave this cycle alone.
          dir_d   = !WR_n;
          cnt_d   = wait_q[region_q];
          state_d = (wait_q[region_q] != '0) ? S_WAIT : S_ACC;
        end else if (tcnt_q == TOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          state_d = S_ACC;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the pins are flop outputs aligned with state_q.
  always_comb begin
    cs_n_d  = '1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ready_d = 1'b1;
    if (state_d == S_ADDR || state_d == S_WAIT || state_d == S_ACC) begin
      cs_n_d[region_d] = 1'b0;
    end else begin
      cs_n_d = '1;
    end
    if (state_d == S_WAIT || state_d == S_ACC) begin
      oe_n_d = dir_d;
      we_n_d = !dir_d;
    end else begin
      oe_n_d = 1'b1;
      we_n_d = 1'b1;
    end
    if (state_d == S_WAIT) begin
      ready_d = 1'b0;
    end else begin
      ready_d = 1'b1;
    end
  end

  // Wait-count register file update; out-of-range selects are dropped.
  always_comb begin
    wait_d = wait_q;
    if (cfg_we && (cfg_sel < 3'(NREG))) begin
      wait_d[cfg_sel] = cfg_wait;
    end else begin
      wait_d = wait_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      region_q <= 3'd0;
      laddr_q  <= 20'd0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      cs_n_q   <= '1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) wait_q[i] <= WAIT_W'(DEFAULT_WAIT);
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      laddr_q  <= laddr_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  assign LADDR = laddr_q;
  assign CS_n  = cs_n_q;
  assign OE_n  = oe_n_q;
  assign WE_n  = we_n_q;
  assign READY = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed cases plus randomized transactions
// checked cycle by cycle against a transaction-level model of the bus cycle.
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic        ALE, IOM, RD_n, WR_n;
  logic [19:0] A;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [2:0]  cfg_wait;
  logic [19:0] LADDR;
  logic [4:0]  CS_n;
  logic        OE_n, WE_n, READY, err;

  int checks = 0;
  int errors = 0;
  int mwait[5];

  bus_cycle_ctrl dut (
    .CLK(clk), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD_n(RD_n), .WR_n(WR_n), .A(A),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wait(cfg_wait),
    .LADDR(LADDR), .CS_n(CS_n), .OE_n(OE_n), .WE_n(WE_n), .READY(READY), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] cs, input logic oe, input logic we,
                          input logic rdy, input logic e);
    chk({tag, ".CS_n"}, 20'(CS_n), 20'(cs));
    chk({tag, ".OE_n"}, 20'(OE_n), 20'(oe));
    chk({tag, ".WE_n"}, 20'(WE_n), 20'(we));
    chk({tag, ".READY"}, 20'(READY), 20'(rdy));
    chk({tag, ".err"}, 20'(err), 20'(e));
  endtask

  function automatic logic [4:0] cs_of(input int r);
    logic [4:0] v;
    v = 5'h1F;
    v[r] = 1'b0;
    return v;
  endfunction

  task automatic cfg_write(input int s, input int v);
    cfg_we = 1'b1; cfg_sel = 3'(s); cfg_wait = 3'(v);
    tick();
    cfg_we = 1'b0;
    if (s < 5) mwait[s] = v;
  endtask

  // One complete bus cycle; cfg_at: 0 none, 1 on the strobe-sampling edge, 2 in the first wait cycle.
  task automatic run_txn(input string tag, input logic [19:0] a, input logic iom, input logic wr,
                         input int pre, input int cfg_at, input int cs_sel, input int cs_val);
    int r, n;
    logic [4:0] ecs;
    r   = iom ? 4 : int'(a[19:18]);
    ecs = cs_of(r);
    ALE = 1'b1; A = a; IOM = iom; RD_n = 1'b1; WR_n = 1'b1;
    tick();
    ALE = 1'b0; A = 20'($urandom); IOM = 1'($urandom);
    for (int i = 0; i < pre; i++) begin
      chk_outs({tag, ".addr_hold"}, ecs, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk_outs({tag, ".addr"}, ecs, 1'b1, 1'b1, 1'b1, 1'b0);
    chk({tag, ".laddr"}, LADDR, a);
    if (wr) WR_n = 1'b0; else RD_n = 1'b0;
    if (cfg_at == 1) begin cfg_we = 1'b1; cfg_sel = 3'(cs_sel); cfg_wait = 3'(cs_val); end
    n = mwait[r];
    tick();
    if (cfg_at == 1) begin cfg_we = 1'b0; if (cs_sel < 5) mwait[cs_sel] = cs_val; end
    for (int i = 0; i < n; i++) begin
      chk_outs({tag, ".wait"}, ecs, wr, !wr, 1'b0, 1'b0);
      chk({tag, ".laddr_w"}, LADDR, a);
      if (i == 0 && cfg_at == 2) begin cfg_we = 1'b1; cfg_sel = 3'(cs_sel); cfg_wait = 3'(cs_val); end
      ALE = 1'($urandom); A = 20'($urandom);
      if ($urandom_range(0, 3) == 0) begin RD_n = 1'b1; WR_n = 1'b1; end
      tick();
      if (i == 0 && cfg_at == 2) begin cfg_we = 1'b0; if (cs_sel < 5) mwait[cs_sel] = cs_val; end
    end
    chk_outs({tag, ".acc"}, ecs, wr, !wr, 1'b1, 1'b0);
    chk({tag, ".laddr_a"}, LADDR, a);
    ALE = 1'b0; RD_n = 1'b1; WR_n = 1'b1;
    tick();
    chk_outs({tag, ".done"}, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_outs({tag, ".idle"}, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);
    chk({tag, ".laddr_i"}, LADDR, a);
  endtask

  initial begin
    logic [4:0] ecs;
    RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD_n = 1'b1; WR_n = 1'b1; A = 20'h0;
    cfg_we = 1'b0; cfg_sel = 3'd0; cfg_wait = 3'd0;
    for (int i = 0; i < 5; i++) mwait[i] = 1;
    #12;
    chk_outs("reset", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset.laddr", LADDR, 20'h0);
    @(negedge clk) RESET = 1'b0;

    // Memory read bank 1 with default single wait.
    run_txn("mem_rd", 20'h40010, 1'b0, 1'b0, 0, 0, 0, 0);
    // Zero-wait write to bank 3.
    cfg_write(3, 0);
    run_txn("wr0", 20'hC0000, 1'b0, 1'b1, 0, 0, 0, 0);
    // I/O read with seven waits, A[19:18] ignored.
    cfg_write(4, 7);
    run_txn("io7", 20'hC0080, 1'b1, 1'b0, 0, 0, 0, 0);

    // Timeout: no strobe for eight ADDR cycles.
    ALE = 1'b1; A = 20'h81234; IOM = 1'b0;
    tick();
    ALE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_outs("tmo_addr", cs_of(2), 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    chk_outs("tmo_err", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_outs("tmo_clr", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);

    // Both strobes low in ADDR.
    ALE = 1'b1; A = 20'h00055; IOM = 1'b0;
    tick();
    ALE = 1'b0; RD_n = 1'b0; WR_n = 1'b0;
    chk_outs("both_addr", cs_of(0), 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    RD_n = 1'b1; WR_n = 1'b1;
    chk_outs("both_err", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_outs("both_clr", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);

    // Config during a region-1 wait keeps the old count; next cycle uses the new one.
    run_txn("cfg_mid", 20'h41234, 1'b0, 1'b0, 1, 2, 1, 5);
    run_txn("cfg_new", 20'h45678, 1'b0, 1'b1, 0, 0, 0, 0);
    // Config on the load edge: load sees the old value.
    run_txn("cfg_load", 20'h00100, 1'b0, 1'b0, 0, 1, 0, 4);
    run_txn("cfg_load2", 20'h00200, 1'b0, 1'b0, 0, 0, 0, 0);
    // Out-of-range select is ignored.
    cfg_write(6, 7);
    run_txn("sel_oob", 20'h80000, 1'b0, 1'b0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a WAIT.
    cfg_write(2, 3);
    ALE = 1'b1; A = 20'h8ABCD; IOM = 1'b0;
    tick();
    ALE = 1'b0; RD_n = 1'b0;
    tick();
    chk_outs("pre_rst_wait", cs_of(2), 1'b0, 1'b1, 1'b0, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk_outs("async_rst", 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("async_rst.laddr", LADDR, 20'h0);
    RD_n = 1'b1;
    for (int i = 0; i < 5; i++) mwait[i] = 1;
    @(negedge clk) RESET = 1'b0;
    run_txn("post_rst", 20'h80004, 1'b0, 1'b0, 0, 0, 0, 0);
    run_txn("post_rst_io", 20'h00004, 1'b1, 1'b1, 0, 0, 0, 0);

    // Randomized transactions against the model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      run_txn("rand", 20'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    ecs = 5'h1F;
    chk_outs("final_idle", ecs, 1'b1, 1'b1, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
